// File: rtl/ps2_pkg.sv
// ps2_pkg: shared prefix constants, prefix FSM states and the queued key event type
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} ps2_state_t;
  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       rel;
    logic       ext;
    logic       rpt;
  } ps2_evt_t;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: DEPTH-entry key event queue with sticky overflow on dropped pushes
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clock,
  input  logic     resetn,
  input  logic     push,
  input  ps2_evt_t din,
  input  logic     pop,
  output ps2_evt_t dout,
  output logic     valid,
  output logic     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  ps2_evt_t mem [DEPTH];
  logic empty, full, do_pop, do_push;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign valid = !empty;
  assign dout = empty ? '0 : mem[rd_q[AW-1:0]];
  // pointers and sticky overflow
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end
  // event storage
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ps2_to_ascii.sv
// ps2_to_ascii: set-2 scancode to lowercase ASCII lookup, 8'h00 when unmapped
module ps2_to_ascii (
  input  logic [7:0] scan_code,
  output logic [7:0] ascii
);
  // combinational lookup table
  always_comb begin
    ascii = 8'h00;
    case (scan_code)
      8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63; 8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66; 8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69; 8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F; 8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72; 8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75; 8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A; 8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32; 8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38; 8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20; 8'h5A: ascii = 8'h0D; 8'h66: ascii = 8'h08; 8'h76: ascii = 8'h1B;
      default: ascii = 8'h00;
    endcase
  end
endmodule

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: PS/2 make/break/E0 decoder with typematic suppression and event FIFO; PS2_AUTOREPEAT_EN adds internal auto-repeat
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMER_W      = 25,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 2_500_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic [7:0] evt_ascii,
  output logic       evt_release,
  output logic       evt_extended,
  output logic       evt_repeat,
  output logic       overflow
);
  ps2_state_t state_q, state_d;
  logic is_e0, is_f0, dec_valid, dec_rel, dec_ext;
  logic held_valid_q, held_ext_q, held_match, dup, push_dec, new_key, rpt_push, lk_ext;
  logic [7:0] held_code_q, lk_code, lk_ascii;
  ps2_evt_t push_evt, head;
  assign is_e0 = scan_code == PS2_EXT;
  assign is_f0 = scan_code == PS2_BREAK;
  // prefix state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else state_q <= state_d;
  end
  // prefix next state and decoded make/break
  always_comb begin
    state_d = state_q;
    dec_valid = 1'b0;
    dec_rel = 1'b0;
    dec_ext = 1'b0;
    if (scan_valid)
      case (state_q)
        IDLE: begin
          state_d = is_e0 ? GOT_E0 : is_f0 ? GOT_F0 : IDLE;
          dec_valid = !is_e0 && !is_f0;
        end
        GOT_E0: begin
          state_d = is_f0 ? GOT_E0F0 : is_e0 ? GOT_E0 : IDLE;
          dec_valid = !is_e0 && !is_f0;
          dec_ext = 1'b1;
        end
        GOT_F0: begin
          state_d = is_e0 ? GOT_E0 : IDLE;
          dec_valid = !is_e0;
          dec_rel = 1'b1;
        end
        default: begin
          state_d = IDLE;
          dec_valid = 1'b1;
          dec_rel = 1'b1;
          dec_ext = 1'b1;
        end
      endcase
  end
  assign held_match = held_valid_q && held_code_q == scan_code && held_ext_q == dec_ext;
  assign dup = dec_valid && !dec_rel && held_match;
  assign push_dec = dec_valid && !dup;
  assign new_key = push_dec && !dec_rel;
  // held key: replaced by a new make, cleared by its own break
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      held_valid_q <= 1'b0;
      held_code_q <= 8'h00;
      held_ext_q <= 1'b0;
    end else if (new_key) begin
      held_valid_q <= 1'b1;
      held_code_q <= scan_code;
      held_ext_q <= dec_ext;
    end else if (push_dec && held_match) begin
      held_valid_q <= 1'b0;
    end
  end
`ifdef PS2_AUTOREPEAT_EN
  logic [TIMER_W-1:0] timer_q;
  logic first_q, fire;
  assign fire = held_valid_q &&
    timer_q == (first_q ? TIMER_W'(REPEAT_DELAY - 1) : TIMER_W'(REPEAT_RATE - 1));
  assign rpt_push = fire && !push_dec;
  // repeat timer: first period is the delay, then the rate; a colliding decoder event still reloads it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
      first_q <= 1'b0;
    end else if (new_key) begin
      timer_q <= '0;
      first_q <= 1'b1;
    end else if (fire) begin
      timer_q <= '0;
      first_q <= 1'b0;
    end else if (held_valid_q) begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMER_W, REPEAT_DELAY, REPEAT_RATE};
  assign rpt_push = 1'b0;
`endif
  assign lk_code = push_dec ? scan_code : held_code_q;
  assign lk_ext = push_dec ? dec_ext : held_ext_q;
  ps2_to_ascii u_ascii (
    .scan_code(lk_code),
    .ascii    (lk_ascii)
  );
  assign push_evt = '{code: lk_code, ascii: lk_ext ? 8'h00 : lk_ascii,
                      rel: push_dec && dec_rel, ext: lk_ext, rpt: !push_dec};
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (push_dec || rpt_push),
    .din     (push_evt),
    .pop     (evt_ready),
    .dout    (head),
    .valid   (evt_valid),
    .overflow(overflow)
  );
  assign evt_code = head.code;
  assign evt_ascii = head.ascii;
  assign evt_release = head.rel;
  assign evt_extended = head.ext;
  assign evt_repeat = head.rpt;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb_ps2_key_event_decoder: scoreboard bench for the PS/2 key event decoder
module tb_ps2_key_event_decoder;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic evt_ready = 1'b0;
  logic evt_valid, evt_release, evt_extended, evt_repeat, overflow;
  logic [7:0] evt_code, evt_ascii;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [18:0] exp_q[$];
  logic [18:0] head_exp;
  int rpt_cyc[$];

  ps2_key_event_decoder #(
    .FIFO_DEPTH(4), .TIMER_W(8), .REPEAT_DELAY(10), .REPEAT_RATE(4)
  ) dut (
    .clock(clock), .resetn(resetn), .scan_valid(scan_valid), .scan_code(scan_code),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_ascii(evt_ascii),
    .evt_release(evt_release), .evt_extended(evt_extended), .evt_repeat(evt_repeat),
    .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] asc(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h61;
      8'h32: return 8'h62;
      8'h21: return 8'h63;
      8'h23: return 8'h64;
      8'h24: return 8'h65;
      8'h29: return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [18:0] ev(input logic [7:0] c, input logic r, input logic x, input logic p);
    return {c, x ? 8'h00 : asc(c), r, x, p};
  endfunction

  always @(negedge clock) begin
    if (resetn && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) check("unexpected_evt", 32'(exp_q.size()), 1);
      else begin
        head_exp = exp_q.pop_front();
        check("evt", 32'({evt_code, evt_ascii, evt_release, evt_extended, evt_repeat}), 32'(head_exp));
        if (evt_repeat) rpt_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    scan_code = b;
    scan_valid = 1'b1;
    @(posedge clock);
    #1 scan_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic check_idle(input string tag);
    check(tag, 32'({evt_valid, evt_code, evt_ascii, evt_release, evt_extended, evt_repeat, overflow}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] keys [5];
    int c0, n;
    keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    #1 check_idle("reset_outputs");
    tick();
    tick();
    resetn = 1'b1;
    check_idle("idle_after_reset");
    evt_ready = 1'b1;
    exp_q.push_back(ev(8'h1C, 0, 0, 0));
    exp_q.push_back(ev(8'h1C, 1, 0, 0));
    send(8'h1C); send(8'hF0); send(8'h1C);
    wait_drain("press_release");
    exp_q.push_back(ev(8'h75, 0, 1, 0));
    exp_q.push_back(ev(8'h75, 1, 1, 0));
    exp_q.push_back(ev(8'h5A, 0, 1, 0));
    exp_q.push_back(ev(8'h5A, 1, 1, 0));
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
    wait_drain("extended");
    exp_q.push_back(ev(8'h1C, 0, 0, 0));
    exp_q.push_back(ev(8'h1C, 1, 0, 0));
    repeat (5) send(8'h1C);
    send(8'hF0); send(8'h1C);
    wait_drain("typematic");
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(ev(keys[i], 0, 0, 0));
      send(keys[i]);
    end
    check("overflow_set", 32'(overflow), 1);
    check("full_valid", 32'(evt_valid), 1);
    evt_ready = 1'b1;
    wait_drain("overflow_drain");
    tick();
    check("empty_after_drain", 32'(evt_valid), 0);
    evt_ready = 1'b0;
    send(8'h29); send(8'hE0); send(8'hF0);
    check("queued_before_reset", 32'(evt_valid), 1);
    resetn = 1'b0;
    #1 check_idle("reset_mid_sequence");
    tick();
    resetn = 1'b1;
    exp_q.delete();
    send(8'h1C);
    check("latency", 32'(evt_valid), 1);
    exp_q.push_back(ev(8'h1C, 0, 0, 0));
    evt_ready = 1'b1;
    wait_drain("reset_recover");
`ifdef PS2_AUTOREPEAT_EN
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    rpt_cyc.delete();
    exp_q.push_back(ev(8'h29, 0, 0, 0));
    repeat (3) exp_q.push_back(ev(8'h29, 0, 0, 1));
    exp_q.push_back(ev(8'h29, 1, 0, 0));
    c0 = cyc;
    send(8'h29);
    n = 0;
    while (rpt_cyc.size() < 3 && n < 40) begin
      tick();
      n++;
    end
    check("rpt_count", 32'(rpt_cyc.size()), 3);
    for (int i = 0; i < rpt_cyc.size(); i++) check("rpt_cycle", 32'(rpt_cyc[i] - c0), 32'(11 + 4 * i));
    send(8'hF0); send(8'h29);
    repeat (20) tick();
    wait_drain("rpt_stop");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
